square_accum_pipe: RTL and testbench
====================================

// Module: square_accum_pipe
// PURPOSE
//   Parametrised, pipelined squarer with a windowed sum-of-squares accumulator.
//   Takes the ADC sample stream and produces two outputs:
//     - a per-sample square
//     - a mean-square energy sum over a fixed window of N samples
//   Sits between the ADC capture FIFO and the power/RMS readout logic.
//   Supersedes the fixed 10x10 single-cycle multiplier wrapper.
//   Adds: signed mode, valid handshake, pipelining, accumulation.
// PARAMETERS
//   DATA_W     10  sample width in bits
//   SIGNED_IN  0   0: in_data is unsigned; 1: in_data is two's complement
//   PIPE       2   squarer pipeline depth in cycles, 1..4
//   WIN_LOG2   8   accumulation window = 2**WIN_LOG2 samples (1..16)
//   SQ_W       2*DATA_W           square output width (localparam)
//   ACC_W      SQ_W+WIN_LOG2      accumulator width (localparam, cannot overflow)
// PORTS
//   clk        in   1      system clock; all logic on rising edge
//   rst_n      in   1      synchronous reset, active low
//   in_valid   in   1      in_data qualifier; one sample per cycle max
//   in_data    in   DATA_W input sample
//   acc_en     in   1      1: squares feed the accumulator; 0: accumulator holds
//   acc_clr    in   1      synchronous clear of window sum, count and pipeline
//   sq_valid   out  1      sq_data qualifier
//   sq_data    out  SQ_W   in_data squared, unsigned
//   acc_valid  out  1      one-cycle pulse; acc_data holds a completed window sum
//   acc_data   out  ACC_W  sum of squares of the last completed window
//   win_cnt    out  WIN_LOG2  number of squares in the current partial window
// BEHAVIOUR
// Reset (rst_n=0 at a clk edge)
//   - All outputs go to 0, all pipeline valid bits go to 0, accumulator goes to 0.
// Squarer
//   - Latency: sq_valid/sq_data appear exactly PIPE cycles after in_valid/in_data.
//   - Throughput: 1 per cycle. No backpressure; downstream must accept every sq_valid.
//   - SIGNED_IN=1: operand is sign-extended and squared, so the result is always non-negative.
//     Example: -512 (DATA_W=10) -> 262144.
//   - sq_data holds its last value while sq_valid=0.
// Accumulator (driven by sq_valid & acc_en)
//   - Each qualifying square is added to the running sum and win_cnt increments.
//   - On the square that completes the window (win_cnt == 2**WIN_LOG2-1):
//       - next cycle: acc_valid=1 and acc_data = full sum including that square
//       - running sum restarts at 0 and win_cnt at 0
//       - the following sample starts the next window with no gap
//   - acc_data holds until the next completed window.
//   - acc_valid is high for exactly 1 cycle per window.
//   - acc_en=0: squares are still output but not summed; sum and win_cnt hold.
// acc_clr
//   - Zeroes sum and win_cnt, and zeroes pipeline valid bits; in-flight samples are discarded.
//   - acc_data is unchanged.
//   - acc_clr in the same cycle as a window-completing square: clear wins, no acc_valid.
//   - acc_clr together with in_valid: that new sample is accepted into stage 1.
// Reset mid-window
//   - Partial sum is discarded; no acc_valid is emitted.
// Width
//   - ACC_W needs no saturation: (2**DATA_W-1)**2 * 2**WIN_LOG2 < 2**ACC_W.
// STRUCTURE
//   - Shared package daq_arith_pkg:
//       - sq_w(DATA_W) and acc_w(DATA_W,WIN_LOG2) width functions
//       - PIPE_MAX=4 constant
//   - Sub-module sq_pipe (DATA_W, SIGNED_IN, PIPE):
//       - pipelined multiplier with valid shift register and synchronous flush input
//       - instantiated once
//   - The accumulator, window counter and acc_valid logic live in the top module.
// TESTING
//   1. Reset: hold rst_n=0 for 3 cycles with in_valid=1
//      -> sq_valid, acc_valid, acc_data, win_cnt all 0.
//   2. Latency: PIPE=2, unsigned, in_data=1023 pulsed once
//      -> sq_valid high exactly 2 cycles later with sq_data=1046529.
//   3. Signed: SIGNED_IN=1, in_data=10'h200 (-512) and 10'h3FF (-1)
//      -> sq_data 262144 then 1.
//   4. Window: WIN_LOG2=2, acc_en=1, samples 1,2,3,4,5,6,7,8 back-to-back
//      -> acc_valid pulses twice with acc_data=30 then 174, the pulses 4 cycles apart.
//   5. Clear collision: WIN_LOG2=2, assert acc_clr on the cycle the 4th square arrives
//      -> no acc_valid, win_cnt=0, acc_data keeps its previous value.
//   6. Hold and reset: acc_en=0 for 3 samples -> win_cnt unchanged;
//      then rst_n=0 mid-window -> no acc_valid; the next window's sum starts from 0.

Source files
------------

// File: rtl/daq_arith_pkg.sv
// Shared arithmetic helpers for the ADC data path: width functions and limits.
package daq_arith_pkg;

   // Deepest squarer pipeline supported.
   localparam int PIPE_MAX = 4;

   // Width of an unsigned square of a data_w-bit sample.
   function automatic int sq_w(input int data_w);
      return 2 * data_w;
   endfunction

   // Width of a sum of 2**win_log2 squares; wide enough that it can never wrap.
   function automatic int acc_w(input int data_w, input int win_log2);
      return 2 * data_w + win_log2;
   endfunction

endpackage

// File: rtl/square_accum_pipe_sq_pipe.sv
// Pipelined squarer with a valid shift register and a synchronous flush.
// The multiply happens ahead of stage 1; later stages only delay the result.
// Each stage's data register loads only when valid moves into it, so the
// output holds its last value while sq_valid is low.
module sq_pipe
   import daq_arith_pkg::*;
#(
   parameter int DATA_W    = 10,
   parameter bit SIGNED_IN = 1'b0,
   parameter int PIPE      = 2,
   localparam int SQ_W     = sq_w(DATA_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              sq_valid,
   output logic [SQ_W-1:0]   sq_data
);

   logic [SQ_W-1:0] operand;
   logic [SQ_W-1:0] square;
   logic [PIPE-1:0] vld;
   logic [SQ_W-1:0] dat [PIPE];

   // Extend the sample to full square width; the product modulo 2**SQ_W is
   // exact because any square of a DATA_W-bit value fits in SQ_W bits.
   always_comb begin
      operand = '0;
      if (SIGNED_IN) begin
         operand = {{DATA_W{in_data[DATA_W-1]}}, in_data};
      end else begin
         operand = {{DATA_W{1'b0}}, in_data};
      end
      square = operand * operand;
   end

   // Stage registers; flush drops in-flight samples but still accepts the new one.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld <= '0;
         for (int i = 0; i < PIPE; i++) begin
            dat[i] <= '0;
         end
      end else begin
         vld[0] <= in_valid;
         if (in_valid) begin
            dat[0] <= square;
         end
         for (int i = 1; i < PIPE; i++) begin
            vld[i] <= vld[i-1] & ~flush;
            if (vld[i-1] && !flush) begin
               dat[i] <= dat[i-1];
            end
         end
      end
   end

   assign sq_valid = vld[PIPE-1];
   assign sq_data  = dat[PIPE-1];

endmodule

// File: rtl/square_accum_pipe.sv
// Squarer plus windowed sum-of-squares accumulator for the ADC sample stream.
// Emits every square and, once per 2**WIN_LOG2 accumulated squares, a one-cycle
// acc_valid pulse with the completed window sum.
module square_accum_pipe
   import daq_arith_pkg::*;
#(
   parameter int DATA_W    = 10,
   parameter bit SIGNED_IN = 1'b0,
   parameter int PIPE      = 2,
   parameter int WIN_LOG2  = 8,
   localparam int SQ_W     = sq_w(DATA_W),
   localparam int ACC_W    = acc_w(DATA_W, WIN_LOG2)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   input  logic [DATA_W-1:0]   in_data,
   input  logic                acc_en,
   input  logic                acc_clr,
   output logic                sq_valid,
   output logic [SQ_W-1:0]     sq_data,
   output logic                acc_valid,
   output logic [ACC_W-1:0]    acc_data,
   output logic [WIN_LOG2-1:0] win_cnt
);

   logic             take;
   logic             win_done;
   logic [ACC_W-1:0] sum;
   logic [ACC_W-1:0] sum_next;

   sq_pipe #(
      .DATA_W    (DATA_W),
      .SIGNED_IN (SIGNED_IN),
      .PIPE      (PIPE)
   ) u_sq_pipe (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (acc_clr),
      .in_valid (in_valid),
      .in_data  (in_data),
      .sq_valid (sq_valid),
      .sq_data  (sq_data)
   );

   // A square counts only when it is valid and accumulation is enabled; the
   // window closes on the square that arrives with the counter at all-ones.
   always_comb begin
      take     = sq_valid & acc_en;
      win_done = take & (&win_cnt);
      sum_next = sum + {{WIN_LOG2{1'b0}}, sq_data};
   end

   // Running sum and window counter; clear beats a window completion in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum       <= '0;
         win_cnt   <= '0;
         acc_valid <= 1'b0;
         acc_data  <= '0;
      end else if (acc_clr) begin
         sum       <= '0;
         win_cnt   <= '0;
         acc_valid <= 1'b0;
      end else begin
         acc_valid <= win_done;
         if (win_done) begin
            acc_data <= sum_next;
            sum      <= '0;
            win_cnt  <= '0;
         end else if (take) begin
            sum     <= sum_next;
            win_cnt <= win_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_square_accum_pipe.sv
// Bench for square_accum_pipe: an unsigned and a signed instance share one
// stimulus stream. Expected squares are queued with their due cycle as inputs
// are driven and popped when due; a small behavioural model tracks the
// accumulator, window count and held outputs of each instance.
module tb_square_accum_pipe;

   localparam int DW   = 10;
   localparam int PIPE = 2;
   localparam int WL2  = 2;
   localparam int WIN  = 4;
   localparam int SQW  = 2 * DW;
   localparam int ACCW = 2 * DW + WL2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          acc_en;
   logic          acc_clr;

   logic            sq_valid  [2];
   logic [SQW-1:0]  sq_data   [2];
   logic            acc_valid [2];
   logic [ACCW-1:0] acc_data  [2];
   logic [WL2-1:0]  win_cnt   [2];

   square_accum_pipe #(.DATA_W(DW), .SIGNED_IN(1'b0), .PIPE(PIPE), .WIN_LOG2(WL2)) dut_u (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .acc_en(acc_en), .acc_clr(acc_clr),
      .sq_valid(sq_valid[0]), .sq_data(sq_data[0]),
      .acc_valid(acc_valid[0]), .acc_data(acc_data[0]), .win_cnt(win_cnt[0])
   );

   square_accum_pipe #(.DATA_W(DW), .SIGNED_IN(1'b1), .PIPE(PIPE), .WIN_LOG2(WL2)) dut_s (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .acc_en(acc_en), .acc_clr(acc_clr),
      .sq_valid(sq_valid[1]), .sq_data(sq_data[1]),
      .acc_valid(acc_valid[1]), .acc_data(acc_data[1]), .win_cnt(win_cnt[1])
   );

   typedef struct {
      longint sq;
      int     due;
   } sb_t;

   typedef struct {
      longint sum;
      longint cnt;
      longint av;
      longint ad;
      longint hold;
   } mdl_t;

   int     n_tests = 0;
   int     n_fail  = 0;
   int     cyc     = 0;
   sb_t    sb_q [2][$];
   mdl_t   mdl  [2];
   longint pulse_val [$];
   int     pulse_cyc [$];

   task automatic check_val(input string tag, input longint obs, input longint exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic longint exp_square(input int j, input logic [DW-1:0] d);
      longint v;
      v = longint'(d);
      if (j == 1 && d[DW-1]) v = v - (longint'(1) << DW);
      return v * v;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard and model: compare current outputs, then advance the model
   // across the coming edge using the inputs driven in this cycle.
   always @(negedge clk) begin
      for (int j = 0; j < 2; j++) begin
         sb_t   arr;
         bit    have;
         string p;
         p    = (j == 0) ? "u" : "s";
         have = 1'b0;
         arr  = '{sq: 0, due: 0};
         while (sb_q[j].size() > 0 && sb_q[j][0].due < cyc) begin
            check_val({p, ".sq_late"}, longint'(cyc), longint'(sb_q[j][0].due));
            void'(sb_q[j].pop_front());
         end
         if (sb_q[j].size() > 0 && sb_q[j][0].due == cyc) begin
            arr  = sb_q[j].pop_front();
            have = 1'b1;
         end
         check_val({p, ".sq_valid"}, longint'(sq_valid[j]), have ? 64'd1 : 64'd0);
         check_val({p, ".sq_data"}, longint'(sq_data[j]), have ? arr.sq : mdl[j].hold);
         check_val({p, ".acc_valid"}, longint'(acc_valid[j]), mdl[j].av);
         check_val({p, ".acc_data"}, longint'(acc_data[j]), mdl[j].ad);
         check_val({p, ".win_cnt"}, longint'(win_cnt[j]), mdl[j].cnt);
         if (j == 0 && acc_valid[0]) begin
            pulse_val.push_back(longint'(acc_data[0]));
            pulse_cyc.push_back(cyc);
         end

         if (!rst_n) begin
            mdl[j] = '{default: 0};
         end else begin
            if (have) mdl[j].hold = arr.sq;
            if (acc_clr) begin
               mdl[j].sum = 0;
               mdl[j].cnt = 0;
               mdl[j].av  = 0;
            end else begin
               mdl[j].av = 0;
               if (have && acc_en) begin
                  if (mdl[j].cnt == WIN - 1) begin
                     mdl[j].ad  = mdl[j].sum + arr.sq;
                     mdl[j].av  = 1;
                     mdl[j].sum = 0;
                     mdl[j].cnt = 0;
                  end else begin
                     mdl[j].sum = mdl[j].sum + arr.sq;
                     mdl[j].cnt = mdl[j].cnt + 1;
                  end
               end
            end
         end
         if (!rst_n || acc_clr) sb_q[j].delete();
         if (rst_n && in_valid) sb_q[j].push_back('{sq: exp_square(j, in_data), due: cyc + PIPE});
      end
   end

   // Drive one cycle of inputs, then advance to just after the next rising edge.
   task automatic step(input logic v, input logic [DW-1:0] d, input logic en, input logic clr);
      in_valid = v;
      in_data  = d;
      acc_en   = en;
      acc_clr  = clr;
      @(posedge clk);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b1;
      in_data  = 10'd77;
      acc_en   = 1'b1;
      acc_clr  = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check_val("rst.sq_valid", longint'(sq_valid[0]), 0);
      check_val("rst.acc_valid", longint'(acc_valid[0]), 0);
      check_val("rst.acc_data", longint'(acc_data[0]), 0);
      check_val("rst.win_cnt", longint'(win_cnt[0]), 0);
      rst_n = 1'b1;
      step(1'b0, '0, 1'b0, 1'b0);

      // Latency: 1023 pulsed once, square due exactly two cycles later.
      step(1'b1, 10'd1023, 1'b0, 1'b0);
      check_val("lat.cyc1_valid", longint'(sq_valid[0]), 0);
      step(1'b0, '0, 1'b0, 1'b0);
      check_val("lat.cyc2_valid", longint'(sq_valid[0]), 1);
      check_val("lat.cyc2_data", longint'(sq_data[0]), 1046529);
      step(1'b0, '0, 1'b0, 1'b0);
      check_val("lat.cyc3_valid", longint'(sq_valid[0]), 0);
      check_val("lat.hold_data", longint'(sq_data[0]), 1046529);
      repeat (2) step(1'b0, '0, 1'b0, 1'b0);

      // Signed operands: -512 and -1.
      step(1'b1, 10'h200, 1'b0, 1'b0);
      step(1'b1, 10'h3FF, 1'b0, 1'b0);
      check_val("sgn.m512", longint'(sq_data[1]), 262144);
      step(1'b0, '0, 1'b0, 1'b0);
      check_val("sgn.m1", longint'(sq_data[1]), 1);
      repeat (3) step(1'b0, '0, 1'b0, 1'b0);

      // Two back-to-back windows of four samples.
      for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b1, 1'b0);
      repeat (6) step(1'b0, '0, 1'b1, 1'b0);
      check_val("win.pulses", longint'(pulse_val.size()), 2);
      if (pulse_val.size() >= 2) begin
         check_val("win.sum0", pulse_val[0], 30);
         check_val("win.sum1", pulse_val[1], 174);
         check_val("win.spacing", longint'(pulse_cyc[1] - pulse_cyc[0]), 4);
      end

      // Clear lands on the cycle the window-completing square arrives.
      for (int i = 9; i <= 12; i++) step(1'b1, DW'(i), 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b1);
      repeat (4) step(1'b0, '0, 1'b1, 1'b0);
      check_val("clr.pulses", longint'(pulse_val.size()), 2);
      check_val("clr.win_cnt", longint'(win_cnt[0]), 0);
      check_val("clr.acc_data", longint'(acc_data[0]), 174);

      // Hold with acc_en low, then reset mid-window.
      step(1'b1, 10'd2, 1'b1, 1'b0);
      step(1'b1, 10'd3, 1'b1, 1'b0);
      repeat (3) step(1'b0, '0, 1'b1, 1'b0);
      check_val("hold.cnt_before", longint'(win_cnt[0]), 2);
      for (int i = 4; i <= 6; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
      repeat (3) step(1'b0, '0, 1'b0, 1'b0);
      check_val("hold.cnt_after", longint'(win_cnt[0]), 2);
      step(1'b1, 10'd7, 1'b1, 1'b0);
      repeat (3) step(1'b0, '0, 1'b1, 1'b0);
      check_val("hold.cnt_three", longint'(win_cnt[0]), 3);
      rst_n = 1'b0;
      repeat (2) step(1'b0, '0, 1'b1, 1'b0);
      rst_n = 1'b1;
      check_val("rstmid.pulses", longint'(pulse_val.size()), 2);
      check_val("rstmid.win_cnt", longint'(win_cnt[0]), 0);
      step(1'b1, 10'd1, 1'b1, 1'b0);
      step(1'b1, 10'd1, 1'b1, 1'b0);
      step(1'b1, 10'd1, 1'b1, 1'b0);
      step(1'b1, 10'd2, 1'b1, 1'b0);
      repeat (4) step(1'b0, '0, 1'b1, 1'b0);
      check_val("rstmid.new_pulses", longint'(pulse_val.size()), 3);
      if (pulse_val.size() >= 3) check_val("rstmid.new_sum", pulse_val[2], 7);

      check_val("sb.drain_u", longint'(sb_q[0].size()), 0);
      check_val("sb.drain_s", longint'(sb_q[1].size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
